// File: rtl/booth_arb_pkg.sv
// Shared constants for the booth_mult_arbiter slice: FSM encoding, datapath widths,
// and the pointer-wrap helper used when BOOTH_ARB_RR_EN is defined.
package booth_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_LAUNCH = 2'b01;
    localparam logic [1:0] ST_WAIT   = 2'b10;
    localparam logic [1:0] ST_RESP   = 2'b11;

    localparam int OPW      = 8;
    localparam int PRW      = 16;
    localparam int NREQ_MAX = 4;

    function automatic int wrap_inc(input int v, input int n);
        if (v + 1 >= n) begin
            return 0;
        end else begin
            return v + 1;
        end
    endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_grant.sv
// Combinational grant: first valid requester found when searching upward from ptr_i,
// wrapping at NREQ. A zero pointer gives plain lowest-index priority.
module rr_grant
    import booth_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            any_o
);

    int cand;

    // Rotated search; the first hit latches and later candidates are ignored.
    always_comb begin
        gnt_oh_o  = {NREQ{1'b0}};
        gnt_idx_o = {IDW{1'b0}};
        any_o     = 1'b0;
        cand      = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end else begin
                cand = cand;
            end
            if (!any_o && (|(req_i & (NREQ'(1'b1) << cand)))) begin
                gnt_oh_o  = NREQ'(1'b1) << cand;
                gnt_idx_o = IDW'(cand);
                any_o     = 1'b1;
            end else begin
                any_o     = any_o;
            end
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one sequential boothMult between NREQ requesters and returns product plus id.
// Define BOOTH_ARB_RR_EN for round-robin grant; otherwise lowest index wins.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                Resetn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_mplier,
    input  logic [OPW*NREQ-1:0] req_mcand,
    output logic                mul_start,
    output logic [OPW-1:0]      mul_mplier,
    output logic [OPW-1:0]      mul_mcand,
    input  logic                mul_finish,
    input  logic [PRW-1:0]      mul_product,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [PRW-1:0]      rsp_product,
    output logic                busy
);

    logic [1:0]      state_q, state_d;
    logic [OPW-1:0]  mplier_q, mplier_d;
    logic [OPW-1:0]  mcand_q, mcand_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [PRW-1:0]  prod_q, prod_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            start_q;

    logic [IDW-1:0]  ptr_s;
    logic [NREQ-1:0] gnt_oh_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic            any_s;
    logic            accept_s;
    logic [OPW-1:0]  sel_mplier_s;
    logic [OPW-1:0]  sel_mcand_s;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_grant (
        .req_i     (req_valid),
        .ptr_i     (ptr_s),
        .gnt_oh_o  (gnt_oh_s),
        .gnt_idx_o (gnt_idx_s),
        .any_o     (any_s)
    );

`ifdef BOOTH_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    // Pointer moves past the requester just served.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s) begin
            ptr_d = IDW'(wrap_inc(int'(gnt_idx_s), NREQ));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (Resetn) begin
            ptr_q <= {IDW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_s = ptr_q;
`else
    assign ptr_s = {IDW{1'b0}};
`endif

    assign sel_mplier_s = OPW'(req_mplier >> (OPW * int'(gnt_idx_s)));
    assign sel_mcand_s  = OPW'(req_mcand >> (OPW * int'(gnt_idx_s)));

    // Requests are only offered a ready while the shared multiplier is free.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        accept_s  = 1'b0;
        if (state_q == ST_IDLE) begin
            req_ready = gnt_oh_s;
            accept_s  = any_s;
        end else begin
            req_ready = {NREQ{1'b0}};
            accept_s  = 1'b0;
        end
    end

    // Next-state and datapath capture; mul_finish only matters in WAIT.
    always_comb begin
        state_d     = state_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        id_d        = id_q;
        prod_d      = prod_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_LAUNCH;
                    mplier_d = sel_mplier_s;
                    mcand_d  = sel_mcand_s;
                    id_d     = gnt_idx_s;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_finish) begin
                    state_d     = ST_RESP;
                    prod_d      = mul_product;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d     = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (Resetn) begin
            state_q     <= ST_IDLE;
            mplier_q    <= {OPW{1'b0}};
            mcand_q     <= {OPW{1'b0}};
            id_q        <= {IDW{1'b0}};
            prod_q      <= {PRW{1'b0}};
            rsp_valid_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            id_q        <= id_d;
            prod_q      <= prod_d;
            rsp_valid_q <= rsp_valid_d;
            start_q     <= accept_s;
        end
    end

    assign mul_start   = start_q;
    assign mul_mplier  = mplier_q;
    assign mul_mcand   = mcand_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter with a behavioural boothMult model.
// Grant expectations follow BOOTH_ARB_RR_EN when it is defined for the build.
module tb_booth_mult_arbiter;

    logic        clk = 1'b0;
    logic        Resetn = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [15:0] req_mplier = 16'h0000;
    logic [15:0] req_mcand = 16'h0000;
    logic        mul_start;
    logic [7:0]  mul_mplier, mul_mcand;
    logic        mul_finish;
    logic [15:0] mul_product;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_product;
    logic        busy;

    int total = 0;
    int bad = 0;
    logic stale_fin = 1'b0;

    typedef struct { logic [1:0] id; logic [15:0] prod; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    booth_mult_arbiter #(.NREQ(2), .IDW(2)) dut (
        .clk(clk), .Resetn(Resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mplier(req_mplier), .req_mcand(req_mcand),
        .mul_start(mul_start), .mul_mplier(mul_mplier), .mul_mcand(mul_mcand),
        .mul_finish(mul_finish), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
    );

    // Multiplier latency: 9 plus the number of Booth recoding transitions (9..17).
    function automatic int booth_lat(input logic [7:0] m);
        int n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m[i] != prev) n++;
            prev = m[i];
        end
        return 9 + n;
    endfunction

    function automatic exp_t mk(input int id, input logic [15:0] p);
        exp_t e;
        e.id = 2'(id);
        e.prod = p;
        return e;
    endfunction

    logic        m_run;
    int          m_cnt;
    logic [15:0] m_res;

    // boothMult model: Finish stays high until the next Start is sampled.
    always @(posedge clk) begin
        if (Resetn) begin
            mul_finish  <= stale_fin;
            mul_product <= stale_fin ? 16'hDEAD : 16'h0000;
            m_run <= 1'b0;
            m_cnt <= 0;
            m_res <= 16'h0000;
        end else if (mul_start) begin
            mul_finish <= 1'b0;
            m_run <= 1'b1;
            m_cnt <= booth_lat(mul_mplier);
            m_res <= 16'($signed(mul_mplier)) * 16'($signed(mul_mcand));
        end else if (m_run) begin
            if (m_cnt <= 1) begin
                mul_finish  <= 1'b1;
                mul_product <= m_res;
                m_run <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Called at a negedge; returns at the negedge of the launch cycle.
    task automatic send(input int r, input logic [7:0] a, input logic [7:0] b);
        bit got = 1'b0;
        req_mplier[r*8 +: 8] = a;
        req_mcand[r*8 +: 8] = b;
        req_valid[r] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (req_ready[r]) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL send_timeout req=%0d req_ready=%b want grant", r, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL rsp_timeout rsp_valid=%b want 1", rsp_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (mul_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl start=%b rsp_valid=%b busy=%b want 0 0 0", mul_start, rsp_valid, busy);
        end
        total++;
        if (rsp_id !== 2'b00 || rsp_product !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rsp id=%0d prod=%h want 0 0000", rsp_id, rsp_product);
        end
        Resetn = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle req_ready=%b busy=%b want 00 0", req_ready, busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        exp_t e;
        rsp_ready = 1'b1;
        sb.push_back(mk(0, 16'hFFF1));
        send(0, 8'd3, 8'hFB);
        total++;
        if (mul_start !== 1'b1 || mul_mplier !== 8'd3 || mul_mcand !== 8'hFB) begin
            bad++;
            $display("FAIL basic_launch start=%b mplier=%h mcand=%h want 1 03 fb", mul_start, mul_mplier, mul_mcand);
        end
        @(negedge clk);
        total++;
        if (mul_start !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_start_pulse start=%b busy=%b want 0 1", mul_start, busy);
        end
        wait_rsp(ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (rsp_id !== e.id || rsp_product !== e.prod) begin
                bad++;
                $display("FAIL basic_rsp id=%0d prod=%h want %0d %h", rsp_id, rsp_product, e.id, e.prod);
            end
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_consumed rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_products();
        int          rid[3] = '{1, 0, 1};
        logic [7:0]  a[3]   = '{8'h80, 8'h7F, 8'h00};
        logic [7:0]  b[3]   = '{8'h80, 8'h7F, 8'hB3};
        logic [15:0] p[3]   = '{16'h4000, 16'h3F01, 16'h0000};
        bit ok;
        exp_t e;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(rid[k], p[k]));
            send(rid[k], a[k], b[k]);
            wait_rsp(ok);
            e = sb.pop_front();
            if (ok) begin
                total++;
                if (rsp_id !== e.id || rsp_product !== e.prod) begin
                    bad++;
                    $display("FAIL product_%0d id=%0d prod=%h want %0d %h", k, rsp_id, rsp_product, e.id, e.prod);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_arbitration();
        bit ok;
        bit got;
        int eg;
        exp_t e;
        rsp_ready = 1'b1;
        req_mplier = {8'hFA, 8'd4};
        req_mcand  = {8'd7, 8'd5};
        req_valid  = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef BOOTH_ARB_RR_EN
            eg = k % 2;
`else
            eg = 0;
`endif
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (req_ready !== 2'b00) begin got = 1'b1; break; end
                @(negedge clk);
            end
            total++;
            if (!got || req_ready !== (2'b01 << eg)) begin
                bad++;
                $display("FAIL arb_grant_%0d req_ready=%b want %b", k, req_ready, 2'b01 << eg);
            end
            sb.push_back(mk(eg, (eg == 0) ? 16'h0014 : 16'hFFD6));
            @(posedge clk);
            @(negedge clk);
            if (k == 3) req_valid = 2'b00;
            wait_rsp(ok);
            e = sb.pop_front();
            if (ok) begin
                total++;
                if (rsp_id !== e.id || rsp_product !== e.prod) begin
                    bad++;
                    $display("FAIL arb_rsp_%0d id=%0d prod=%h want %0d %h", k, rsp_id, rsp_product, e.id, e.prod);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        exp_t e;
        rsp_ready = 1'b0;
        sb.push_back(mk(1, 16'hFFE5));
        send(1, 8'hFD, 8'd9);
        req_mplier[7:0] = 8'd2;
        req_mcand[7:0]  = 8'd2;
        req_valid[0] = 1'b1;
        wait_rsp(ok);
        e = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_product !== e.prod || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL hold_%0d valid=%b id=%0d prod=%h ready=%b want 1 %0d %h 00",
                         i, rsp_valid, rsp_id, rsp_product, req_ready, e.id, e.prod);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL resp_same_cycle req_ready=%b want 00", req_ready);
        end
        @(negedge clk);
        total++;
        if (req_ready !== 2'b01 || busy !== 1'b0) begin
            bad++;
            $display("FAIL regrant_idle req_ready=%b busy=%b want 01 0", req_ready, busy);
        end
        sb.push_back(mk(0, 16'h0004));
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (rsp_id !== e.id || rsp_product !== e.prod) begin
                bad++;
                $display("FAIL regrant_rsp id=%0d prod=%h want %0d %h", rsp_id, rsp_product, e.id, e.prod);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stale_finish();
        bit ok;
        exp_t e;
        rsp_ready = 1'b1;
        stale_fin = 1'b1;
        Resetn = 1'b1;
        repeat (2) @(negedge clk);
        Resetn = 1'b0;
        stale_fin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL stale_idle_%0d busy=%b rsp_valid=%b finish=%b want 0 0", i, busy, rsp_valid, mul_finish);
            end
        end
        sb.push_back(mk(0, 16'hFFD6));
        send(0, 8'hF9, 8'd6);
        wait_rsp(ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (rsp_id !== e.id || rsp_product !== e.prod) begin
                bad++;
                $display("FAIL stale_rsp id=%0d prod=%h want %0d %h", rsp_id, rsp_product, e.id, e.prod);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        exp_t e;
        rsp_ready = 1'b1;
        send(1, 8'h55, 8'd3);
        repeat (5) @(negedge clk);
        Resetn = 1'b1;
        @(negedge clk);
        Resetn = 1'b0;
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle busy=%b rsp_valid=%b start=%b want 0 0 0", busy, rsp_valid, mul_start);
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midreset_no_rsp seen=%b want 0", seen);
        end
        sb.push_back(mk(0, 16'h0006));
        send(0, 8'd2, 8'd3);
        wait_rsp(ok);
        e = sb.pop_front();
        if (ok) begin
            total++;
            if (rsp_id !== e.id || rsp_product !== e.prod) begin
                bad++;
                $display("FAIL midreset_rsp id=%0d prod=%h want %0d %h", rsp_id, rsp_product, e.id, e.prod);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_arbitration();
        test_backpressure();
        test_stale_finish();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
